// File: rtl/cp0_exc_unit.sv
// CP0 coprocessor block: BadVAddr, Count, Compare, Status, Cause and EPC,
// with interrupt gating, a Count prescaler, a sticky timer interrupt and
// exception entry/return sequencing for the MEM stage.
module cp0_exc_unit #(
    parameter int          NUM_HW_INT       = 6,
    parameter int          COUNT_DIV        = 2,
    parameter int          TIMER_ZERO_GUARD = 1,
    parameter logic [31:0] EXC_VECTOR       = 32'hBFC0_0380,
    parameter logic [31:0] INT_VECTOR       = 32'hBFC0_0380,
    parameter logic [31:0] PC_RESET         = 32'hBFC0_0000
) (
    input  logic                  cpu_clk_50M,
    input  logic                  cpu_rst,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [31:0]           wdata,
    input  logic                  re,
    input  logic [4:0]            raddr,
    output logic [31:0]           rdata,
    input  logic [NUM_HW_INT-1:0] int_i,
    input  logic [31:0]           pc_i,
    input  logic                  in_delay_i,
    input  logic [4:0]            exccode_i,
    input  logic [31:0]           badvaddr_i,
    output logic                  flush,
    output logic                  flush_im,
    output logic [31:0]           cp0_excaddr,
    output logic                  int_req,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic                  timer_int_o
);

    localparam logic [4:0]  REG_BADVADDR = 5'd8;
    localparam logic [4:0]  REG_COUNT    = 5'd9;
    localparam logic [4:0]  REG_COMPARE  = 5'd11;
    localparam logic [4:0]  REG_STATUS   = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;

    localparam logic [4:0]  EXC_NONE = 5'h10;
    localparam logic [4:0]  EXC_ERET = 5'h11;
    localparam logic [4:0]  EXC_INT  = 5'h00;
    localparam logic [4:0]  EXC_ADEL = 5'h04;
    localparam logic [4:0]  EXC_ADES = 5'h05;

    localparam logic [31:0] STATUS_MASK  = 32'h1000_FF03;
    localparam logic [31:0] STATUS_RESET = 32'h1000_0000;
    localparam logic [3:0]  PRESC_MAX    = 4'(COUNT_DIV - 1);

    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [3:0]  presc_q, presc_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] status_q, status_d;
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;
    logic        timer_q, timer_d;
    logic        int_req_q, int_req_d;
    logic        flush_im_q;

    logic [31:0] cause_q;
    logic [5:0]  hw_pad;
    logic        is_exc, is_eret, wr_ok, timer_hit;

    assign cause_q = {bd_q, ti_q, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b0};

    assign is_eret = (exccode_i == EXC_ERET);
    assign is_exc  = (exccode_i != EXC_NONE) && !is_eret;
    // An mtc0 that coincides with an exception or ERET is discarded.
    assign wr_ok   = we && !is_exc && !is_eret;

    // Next-state logic for every CP0 field.
    always_comb begin
        hw_pad     = '0;
        for (int i = 0; i < NUM_HW_INT; i++) hw_pad[i] = int_i[i];

        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        presc_d    = presc_q;
        compare_d  = compare_q;
        status_d   = status_q;
        bd_d       = bd_q;
        epc_d      = epc_q;
        exccode_d  = exccode_q;
        ip_sw_d    = ip_sw_q;

        ip_hw_d    = {hw_pad[5] | timer_q, hw_pad[4:0]};
        ti_d       = timer_q;

        if (wr_ok && waddr == REG_COUNT) begin
            count_d = wdata;
            presc_d = '0;
        end else if (presc_q == PRESC_MAX) begin
            count_d = count_q + 32'd1;
            presc_d = '0;
        end else begin
            presc_d = presc_q + 4'd1;
        end

        if (wr_ok && waddr == REG_COMPARE) compare_d = wdata;
        if (wr_ok && waddr == REG_STATUS)  status_d  = wdata & STATUS_MASK;
        if (wr_ok && waddr == REG_CAUSE)   ip_sw_d   = wdata[9:8];
        if (wr_ok && waddr == REG_EPC)     epc_d     = wdata;

        if (is_exc) begin
            if (!status_q[1]) begin
                epc_d = in_delay_i ? (pc_i - 32'd4) : pc_i;
                bd_d  = in_delay_i;
            end
            status_d[1] = 1'b1;
            exccode_d   = exccode_i;
            if (exccode_i == EXC_ADEL || exccode_i == EXC_ADES) badvaddr_d = badvaddr_i;
        end else if (is_eret) begin
            status_d[1] = 1'b0;
        end

        // Compare against the Count value being loaded so the flag rises on
        // the same edge Count reaches Compare.
        timer_hit = (count_d == compare_q) && ((TIMER_ZERO_GUARD == 0) || (compare_q != 32'd0));
        if (wr_ok && waddr == REG_COMPARE) timer_d = 1'b0;
        else                               timer_d = timer_q | timer_hit;

        int_req_d = status_q[0] && !status_q[1] && |(cause_q[15:8] & status_q[15:8]);
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            presc_q    <= '0;
            compare_q  <= '0;
            status_q   <= STATUS_RESET;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
            exccode_q  <= '0;
            epc_q      <= '0;
            timer_q    <= 1'b0;
            int_req_q  <= 1'b0;
            flush_im_q <= 1'b0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            compare_q  <= compare_d;
            status_q   <= status_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
            epc_q      <= epc_d;
            timer_q    <= timer_d;
            int_req_q  <= int_req_d;
            flush_im_q <= flush;
        end
    end

    // Redirect address and flush; ERET forwards a same-cycle EPC write.
    always_comb begin
        flush       = 1'b0;
        cp0_excaddr = 32'd0;
        if (cpu_rst) begin
            cp0_excaddr = PC_RESET;
        end else if (exccode_i != EXC_NONE) begin
            flush = 1'b1;
            if (exccode_i == EXC_INT)      cp0_excaddr = INT_VECTOR;
            else if (is_eret)              cp0_excaddr = (we && waddr == REG_EPC) ? wdata : epc_q;
            else                           cp0_excaddr = EXC_VECTOR;
        end
    end

    // mfc0 read port, no write bypass.
    always_comb begin
        rdata = 32'd0;
        if (!cpu_rst && re) begin
            case (raddr)
                REG_BADVADDR: rdata = badvaddr_q;
                REG_COUNT:    rdata = count_q;
                REG_COMPARE:  rdata = compare_q;
                REG_STATUS:   rdata = status_q;
                REG_CAUSE:    rdata = cause_q;
                REG_EPC:      rdata = epc_q;
                default:      rdata = 32'd0;
            endcase
        end
    end

    assign flush_im    = flush_im_q;
    assign int_req     = int_req_q;
    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign timer_int_o = timer_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit with hand-computed expectations.
module tb_cp0_exc_unit;

    localparam logic [4:0] NONE = 5'h10, ERET = 5'h11;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [5:0]  int_in;
    logic [31:0] pc;
    logic        in_delay;
    logic [4:0]  exccode;
    logic [31:0] badvaddr;
    logic        flush, flush_im, int_req, timer_int;
    logic [31:0] excaddr, status, cause, epc;

    int checks = 0;
    int errors = 0;

    cp0_exc_unit dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .re          (re),
        .raddr       (raddr),
        .rdata       (rdata),
        .int_i       (int_in),
        .pc_i        (pc),
        .in_delay_i  (in_delay),
        .exccode_i   (exccode),
        .badvaddr_i  (badvaddr),
        .flush       (flush),
        .flush_im    (flush_im),
        .cp0_excaddr (excaddr),
        .int_req     (int_req),
        .status_o    (status),
        .cause_o     (cause),
        .epc_o       (epc),
        .timer_int_o (timer_int)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    function automatic logic [31:0] rd(input logic [4:0] a);
        return 32'd0;
    endfunction

    initial begin
        logic done, early;
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; re = 1'b1; raddr = 5'd12;
        int_in = '0; pc = '0; in_delay = 1'b0; exccode = 5'h00; badvaddr = '0;
        #1;
        chk("rst_flush", {31'b0, flush}, 0);
        chk("rst_excaddr", excaddr, 32'hBFC0_0000);
        chk("rst_rdata", rdata, 0);
        tick(); tick();
        chk("rst_status", status, 32'h1000_0000);
        chk("rst_flush_im", {31'b0, flush_im}, 0);
        exccode = NONE;
        rst = 1'b0;

        repeat (10) tick();
        raddr = 5'd9; #1;
        chk("idle_count", rdata, 5);
        chk("idle_status", status, 32'h1000_0000);
        chk("idle_int_req", {31'b0, int_req}, 0);
        chk("idle_excaddr", excaddr, 0);
        raddr = 5'd3; #1;
        chk("unmapped_rd", rdata, 0);
        re = 1'b0; raddr = 5'd12; #1;
        chk("re_low_rd", rdata, 0);
        re = 1'b1; raddr = 5'd9;

        // Timer
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd8);
        done = 1'b0; early = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            tick();
            if (rdata == 32'd8) done = 1'b1;
            else if (timer_int) early = 1'b1;
        end
        chk("timer_early", {31'b0, early}, 0);
        chk("timer_reach8", {31'b0, done}, 1);
        chk("timer_set", {31'b0, timer_int}, 1);
        chk("cause_ti_lag", {31'b0, cause[30]}, 0);
        tick();
        chk("cause_ti", {31'b0, cause[30]}, 1);
        chk("cause_ip7", {31'b0, cause[15]}, 1);
        chk("timer_sticky", {31'b0, timer_int}, 1);
        mtc0(5'd11, 32'd20);
        chk("timer_clear", {31'b0, timer_int}, 0);
        mtc0(5'd11, 32'd0);

        // Interrupt request and INT entry
        mtc0(5'd12, 32'h0000_0401);
        int_in = 6'b000001;
        tick();
        chk("int_req_lat1", {31'b0, int_req}, 0);
        tick();
        chk("int_req_lat2", {31'b0, int_req}, 1);
        exccode = 5'h00; pc = 32'h8000_0100; #1;
        chk("int_flush", {31'b0, flush}, 1);
        chk("int_excaddr", excaddr, 32'hBFC0_0380);
        tick();
        exccode = NONE; int_in = '0;
        chk("int_epc", epc, 32'h8000_0100);
        chk("int_exl", {31'b0, status[1]}, 1);
        chk("int_exccode", {27'b0, cause[6:2]}, 0);
        chk("int_flush_im", {31'b0, flush_im}, 1);
        tick();
        chk("int_req_drop", {31'b0, int_req}, 0);

        // Address errors, delay slot and nested exception
        mtc0(5'd12, 32'h0000_0400);
        exccode = 5'h04; in_delay = 1'b1; pc = 32'h8000_0204; badvaddr = 32'h3; #1;
        chk("adel_excaddr", excaddr, 32'hBFC0_0380);
        tick();
        exccode = NONE; in_delay = 1'b0;
        raddr = 5'd8; #1;
        chk("adel_epc", epc, 32'h8000_0200);
        chk("adel_bd", {31'b0, cause[31]}, 1);
        chk("adel_badvaddr", rdata, 32'h3);
        chk("adel_exccode", {27'b0, cause[6:2]}, 4);
        exccode = 5'h05; pc = 32'h8000_0300; badvaddr = 32'h10;
        tick();
        exccode = NONE; #1;
        chk("ades_epc_keep", epc, 32'h8000_0200);
        chk("ades_exccode", {27'b0, cause[6:2]}, 5);
        chk("ades_badvaddr", rdata, 32'h10);

        // ERET, plain and with forwarded EPC write
        exccode = ERET; #1;
        chk("eret_excaddr", excaddr, 32'h8000_0200);
        we = 1'b1; waddr = 5'd14; wdata = 32'h8000_0040; #1;
        chk("eret_fwd", excaddr, 32'h8000_0040);
        chk("eret_flush", {31'b0, flush}, 1);
        tick();
        we = 1'b0; exccode = NONE; #1;
        chk("eret_epc_keep", epc, 32'h8000_0200);
        chk("eret_exl", {31'b0, status[1]}, 0);
        chk("eret_flush_im", {31'b0, flush_im}, 1);

        // Field write masks
        mtc0(5'd13, 32'hFFFF_FFFF);
        int_in = 6'b000100;
        mtc0(5'd12, 32'hFFFF_FFFF);
        raddr = 5'd12; #1;
        chk("status_mask", rdata, 32'h1000_FF03);
        chk("cause_mask", cause, 32'h8000_1314);

        // Reset mid-operation beats a same-cycle exception and write
        rst = 1'b1; exccode = 5'h04; we = 1'b1; waddr = 5'd14; wdata = 32'h1234_5678;
        tick();
        rst = 1'b0; exccode = NONE; we = 1'b0; int_in = '0; #1;
        chk("rst2_epc", epc, 0);
        chk("rst2_status", status, 32'h1000_0000);
        chk("rst2_cause", cause, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
